// File: rtl/window7_gen.sv
// window7_gen: 7-tap horizontal sliding window over a raster stream with edge replication
module window7_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WIDTH = 640,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  win_valid,
    output logic                  win_last,
    output logic [DATA_WIDTH-1:0] w1,
    output logic [DATA_WIDTH-1:0] w2,
    output logic [DATA_WIDTH-1:0] w3,
    output logic [DATA_WIDTH-1:0] w4,
    output logic [DATA_WIDTH-1:0] w5,
    output logic [DATA_WIDTH-1:0] w6,
    output logic [DATA_WIDTH-1:0] w7,
    output logic [CNT_WIDTH-1:0]  win_x
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(LINE_WIDTH - 1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t                  state, state_n;
    logic [CNT_WIDTH-1:0]    cnt, cnt_n, x_n;
    logic [1:0]              fcnt, fcnt_n;
    logic [DATA_WIDTH-1:0]   tap [7];
    logic [DATA_WIDTH-1:0]   tap_n [7];
    logic [DATA_WIDTH-1:0]   fresh;
    logic                    accept, shift, valid_n, last_n;

    assign accept = in_valid && in_ready;
    assign w1 = tap[0];
    assign w2 = tap[1];
    assign w3 = tap[2];
    assign w4 = tap[3];
    assign w5 = tap[4];
    assign w6 = tap[5];
    assign w7 = tap[6];

    // Next state: the taps are the last 7 pixels; p[0] fills every slot (left
    // replication) and FLUSH re-shifts the newest pixel (right replication).
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fcnt_n  = fcnt;
        valid_n = 1'b0;
        last_n  = 1'b0;
        x_n     = win_x;
        shift   = (state == FLUSH) || accept;
        fresh   = (state == FLUSH) ? tap[6] : in_data;
        for (int i = 0; i < 6; i++)
            tap_n[i] = !shift ? tap[i] : (state == FILL && cnt == '0) ? fresh : tap[i+1];
        tap_n[6] = shift ? fresh : tap[6];
        case (state)
            FILL: if (accept) begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_WIDTH'(2)) state_n = RUN;
            end
            RUN: if (accept) begin
                valid_n = 1'b1;
                x_n     = cnt - CNT_WIDTH'(3);
                if (cnt == LAST) state_n = FLUSH;
                else cnt_n = cnt + 1'b1;
            end
            FLUSH: begin
                valid_n = 1'b1;
                x_n     = win_x + 1'b1;
                fcnt_n  = fcnt + 1'b1;
                if (fcnt == 2'd2) begin
                    last_n  = 1'b1;
                    fcnt_n  = '0;
                    cnt_n   = '0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // State and registered outputs; reset drops any partial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            cnt       <= '0;
            fcnt      <= '0;
            in_ready  <= 1'b1;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_x     <= '0;
            for (int i = 0; i < 7; i++) tap[i] <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            fcnt      <= fcnt_n;
            in_ready  <= (state_n != FLUSH);
            win_valid <= valid_n;
            win_last  <= last_n;
            win_x     <= x_n;
            for (int i = 0; i < 7; i++) tap[i] <= tap_n[i];
        end
    end
endmodule

// File: doc/window7_gen.md
Name: window7_gen

Overview:
- Upstream feeder for sorter7 in the noise-detection datapath.
- Accepts a raster pixel stream, one pixel per cycle.
- Emits, per pixel position x, a 7-tap horizontal window p[x-3]..p[x+3], with border pixels replicated at line edges.
- Taps w1..w7 drive sorter7 inputs _1.._7 directly; w4 is the centre pixel under test.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- LINE_WIDTH, 640, pixels per line; legal range is LINE_WIDTH >= 4.
- CNT_WIDTH, 10, width of the in-line pixel counter; must satisfy 2^CNT_WIDTH >= LINE_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a pixel.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  DATA_WIDTH  pixel value.
- win_valid  output  1  w1..w7 hold a valid window.
- win_last  output  1  window is the last of its line (x = LINE_WIDTH-1).
- w1..w7  output  DATA_WIDTH each  window taps, w1 = p[x-3], w4 = p[x], w7 = p[x+3].
- win_x  output  CNT_WIDTH  centre position x of the current window.

Behaviour:
- Reset and clock: one clock domain (clk); asynchronous active-low reset (rst_n).
- Reset values: in_ready=1, win_valid=0, win_last=0, w1..w7=0, win_x=0. Pixel counter is 0 and state is FILL.
- Asserting rst_n mid-line discards the partial line. The next accepted pixel is p[0] of a new line.
- Accept: a pixel is accepted when in_valid && in_ready.
  - in_valid gaps are allowed; the window state holds across gaps.
  - in_data is ignored when in_ready=0.
- Clamping: window taps use index clamp(i) = min(max(i,0), LINE_WIDTH-1).
- All outputs are registered. win_valid is a 1-cycle pulse per window. No output backpressure: the consumer is combinational.
- State FILL (pixel counter k = 0..2):
  - Accept pixels and count them.
  - No window is produced.
  - On accepting p[2], go to RUN.
- State RUN (k = 3..LINE_WIDTH-1): accepting p[k] at cycle t produces window x = k-3 at t+1.
  - Taps below index 0 use p[0].
  - Example: x=0 gives p0,p0,p0,p0,p1,p2,p3.
  - On accepting p[LINE_WIDTH-1], go to FLUSH.
- State FLUSH: exactly 3 cycles, with in_ready=0 during them.
  - If p[LINE_WIDTH-1] was accepted at cycle t, in_ready is 0 at t+1..t+3 and returns to 1 at t+4.
  - FLUSH cycles produce windows x = LINE_WIDTH-3, LINE_WIDTH-2, LINE_WIDTH-1, valid at t+2, t+3, t+4.
  - Taps above index LINE_WIDTH-1 use p[LINE_WIDTH-1].
  - win_last=1 only together with x = LINE_WIDTH-1.
  - After the third FLUSH cycle, the pixel counter is 0 and state returns to FILL.
- Count: exactly LINE_WIDTH windows per line, in strictly increasing x. win_x matches the window's centre.
- Line boundary: nothing from the previous line appears in any window of the next line.
- Degenerate width: with LINE_WIDTH=4, RUN lasts one pixel (k=3).
- Counter: the pixel counter never exceeds LINE_WIDTH-1. Wrap to 0 happens only at FLUSH exit.

Test Plan (LINE_WIDTH=8, DATA_WIDTH=8):
1. Reset, then stream 10,20,...,80 with in_valid held high.
   - When 40 is accepted, the next cycle shows win_valid=1, x=0, taps 10,10,10,10,20,30,40.
   - x=1 shows 10,10,10,20,30,40,50.
2. Same stream, tail of the line.
   - x=4 shows 20,30,40,50,60,70,80, valid the cycle after 80 is accepted.
   - in_ready=0 for exactly 3 cycles.
   - x=5 shows 30,40,50,60,70,80,80; x=6 shows 40,50,60,70,80,80,80.
   - x=7 shows 50,60,70,80,80,80,80 with win_last=1.
   - Exactly 8 windows are produced.
3. Two back-to-back lines: 10..80, then 1,2,...,8 driven continuously.
   - in_data offered during the in_ready=0 cycles is not consumed.
   - Second-line x=0 shows 1,1,1,1,2,3,4; no tap ever holds a value from line 1.
4. Line 10..80 with in_valid dropped for 5 cycles after pixel 50.
   - No win_valid during the gap.
   - Window sequence and values are identical to scenario 1/2.
5. Assert rst_n low while in RUN after pixel 60.
   - All outputs go to 0 asynchronously and in_ready=1.
   - A new line 100,110,...,170 then gives x=0 taps 100,100,100,100,110,120,130.
6. Feed windows into sorter7.
   - Line 0,0,255,0,0,0,0,0 gives window x=2 taps 0,0,0,255,0,0,0.
   - Sorter outputs are min=0, med=0, max=255.
